// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: jump classes, link register, write-back state.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JAL  = 2'b10;
    localparam logic [1:0] JUMP_JR   = 2'b11;

    localparam logic [4:0] REG_RA    = 5'd31;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_t;

    // jal always links into r31 regardless of RegDst.
    function automatic logic [4:0] wb_dest(input logic [1:0] jump,
                                           input logic       reg_dst,
                                           input logic [4:0] rd,
                                           input logic [4:0] rt);
        if (jump == JUMP_JAL)
            return REG_RA;
        else if (reg_dst)
            return rd;
        else
            return rt;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register storage: two combinational read ports, one synchronous write port.
// Latency: reads 0 cycles, write visible after the next rising clk.
// Backpressure: none; r0 reads 0 and ignores writes.
module regfile_2r1w (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] mem [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                mem[i] <= 32'h0;
        end else if (we && (waddr != 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : mem[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: destination/data select, register file with write-through bypass, halt FSM, retire counter.
// Latency: write-back data is readable the same cycle via bypass and from storage after the next rising clk.
// Backpressure: none; once halted, writes and counting stop until reset.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_mem_wb,
    input  logic [31:0]         instruction_mem_wb,
    input  logic                MemtoReg_mem_wb,
    input  logic [1:0]          Jump_mem_wb,
    input  logic [4:0]          rt_mem_wb,
    input  logic [4:0]          rd_mem_wb,
    input  logic [31:0]         alu_out_mem_wb,
    input  logic [31:0]         ram_read_data_mem_wb,
    input  logic                RegDst_mem_wb,
    input  logic                RegWrite_mem_wb,
    input  logic                halt_mem_wb,
    input  logic [4:0]          ra_addr,
    input  logic [4:0]          rb_addr,
    output logic [31:0]         ra_data,
    output logic [31:0]         rb_data,
    output logic                wb_we,
    output logic [4:0]          wb_addr,
    output logic [31:0]         wb_data,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired_count
);

    wb_state_t   state;
    logic        is_jal;
    logic [31:0] ra_stored;
    logic [31:0] rb_stored;

    assign is_jal  = (Jump_mem_wb == JUMP_JAL);
    assign wb_addr = wb_dest(Jump_mem_wb, RegDst_mem_wb, rd_mem_wb, rt_mem_wb);

    always_comb begin
        wb_data = alu_out_mem_wb;
        if (is_jal)
            wb_data = pc_mem_wb + 32'd4;
        else if (MemtoReg_mem_wb)
            wb_data = ram_read_data_mem_wb;
    end

    // A write to r0 is dropped here so the forwarding unit never sees it.
    assign wb_we = (RegWrite_mem_wb | is_jal) & ~halted & (wb_addr != 5'd0);

    regfile_2r1w u_regs (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (ra_addr),
        .rdata_a (ra_stored),
        .raddr_b (rb_addr),
        .rdata_b (rb_stored)
    );

    assign ra_data = (wb_we && (ra_addr == wb_addr)) ? wb_data : ra_stored;
    assign rb_data = (wb_we && (rb_addr == wb_addr)) ? wb_data : rb_stored;

    // The halt instruction itself still retires and may write back on its own edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_RUN;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (instruction_mem_wb != 32'h0)
                        retired_count <= retired_count + 1'b1;
                    if (halt_mem_wb) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (4-bit retire counter so wrap is reachable).
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] pc_mem_wb;
    logic [31:0] instruction_mem_wb;
    logic        MemtoReg_mem_wb;
    logic [1:0]  Jump_mem_wb;
    logic [4:0]  rt_mem_wb;
    logic [4:0]  rd_mem_wb;
    logic [31:0] alu_out_mem_wb;
    logic [31:0] ram_read_data_mem_wb;
    logic        RegDst_mem_wb;
    logic        RegWrite_mem_wb;
    logic        halt_mem_wb;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;
    logic [3:0]  retired_count;

    int total = 0;
    int fails = 0;

    wb_regfile #(.RETIRE_W(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pc_mem_wb            (pc_mem_wb),
        .instruction_mem_wb   (instruction_mem_wb),
        .MemtoReg_mem_wb      (MemtoReg_mem_wb),
        .Jump_mem_wb          (Jump_mem_wb),
        .rt_mem_wb            (rt_mem_wb),
        .rd_mem_wb            (rd_mem_wb),
        .alu_out_mem_wb       (alu_out_mem_wb),
        .ram_read_data_mem_wb (ram_read_data_mem_wb),
        .RegDst_mem_wb        (RegDst_mem_wb),
        .RegWrite_mem_wb      (RegWrite_mem_wb),
        .halt_mem_wb          (halt_mem_wb),
        .ra_addr              (ra_addr),
        .rb_addr              (rb_addr),
        .ra_data              (ra_data),
        .rb_data              (rb_data),
        .wb_we                (wb_we),
        .wb_addr              (wb_addr),
        .wb_data              (wb_data),
        .halted               (halted),
        .retired_count        (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pc_mem_wb            = 32'h0;
        instruction_mem_wb   = 32'h0;
        MemtoReg_mem_wb      = 1'b0;
        Jump_mem_wb          = 2'b00;
        rt_mem_wb            = 5'd0;
        rd_mem_wb            = 5'd0;
        alu_out_mem_wb       = 32'h0;
        ram_read_data_mem_wb = 32'h0;
        RegDst_mem_wb        = 1'b0;
        RegWrite_mem_wb      = 1'b0;
        halt_mem_wb          = 1'b0;
    endtask

    task automatic write_rd(input logic [4:0] rd, input logic [31:0] val);
        RegWrite_mem_wb = 1'b1;
        RegDst_mem_wb   = 1'b1;
        rd_mem_wb       = rd;
        alu_out_mem_wb  = val;
    endtask

    initial begin
        idle();
        ra_addr = 5'd0;
        rb_addr = 5'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ra_addr = 5'd31;
        #1;
        chk("reset_halted", {31'h0, halted}, 32'h0);
        chk("reset_count", {28'h0, retired_count}, 32'h0);
        chk("reset_r31", ra_data, 32'h0);
        rst = 1'b0;
        tick();

        // ALU write to rd=5, bypass in the same cycle, stored value next cycle
        write_rd(5'd5, 32'hDEADBEEF);
        rt_mem_wb = 5'd9;
        ra_addr = 5'd5;
        rb_addr = 5'd5;
        #1;
        chk("alu_we", {31'h0, wb_we}, 32'h1);
        chk("alu_addr", {27'h0, wb_addr}, 32'd5);
        chk("alu_bypass_a", ra_data, 32'hDEADBEEF);
        chk("alu_bypass_b", rb_data, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("alu_stored", ra_data, 32'hDEADBEEF);
        chk("bubble_no_count", {28'h0, retired_count}, 32'h0);

        // RAM data to rt=9
        RegWrite_mem_wb = 1'b1;
        MemtoReg_mem_wb = 1'b1;
        rt_mem_wb = 5'd9;
        rd_mem_wb = 5'd5;
        alu_out_mem_wb = 32'h11111111;
        ram_read_data_mem_wb = 32'hCAFEF00D;
        #1;
        chk("ram_addr", {27'h0, wb_addr}, 32'd9);
        chk("ram_data", wb_data, 32'hCAFEF00D);
        tick();
        idle();
        ra_addr = 5'd9;
        rb_addr = 5'd5;
        #1;
        chk("ram_stored", ra_data, 32'hCAFEF00D);
        chk("r5_untouched", rb_data, 32'hDEADBEEF);

        // jal links pc+4 into r31 without RegWrite
        Jump_mem_wb = 2'b10;
        pc_mem_wb = 32'h00400010;
        RegDst_mem_wb = 1'b1;
        rd_mem_wb = 5'd5;
        #1;
        chk("jal_we", {31'h0, wb_we}, 32'h1);
        chk("jal_addr", {27'h0, wb_addr}, 32'd31);
        chk("jal_data", wb_data, 32'h00400014);
        tick();
        idle();
        ra_addr = 5'd31;
        #1;
        chk("jal_stored", ra_data, 32'h00400014);

        // pc+4 wraps modulo 2^32 (checked combinationally only)
        Jump_mem_wb = 2'b10;
        pc_mem_wb = 32'hFFFFFFFC;
        #1;
        chk("jal_wrap", wb_data, 32'h0);
        idle();

        // plain j does not write
        Jump_mem_wb = 2'b01;
        pc_mem_wb = 32'h00400020;
        #1;
        chk("j_no_we", {31'h0, wb_we}, 32'h0);
        idle();

        // r0 write discarded
        write_rd(5'd0, 32'h12345678);
        ra_addr = 5'd0;
        #1;
        chk("r0_we", {31'h0, wb_we}, 32'h0);
        chk("r0_bypass", ra_data, 32'h0);
        tick();
        idle();
        #1;
        chk("r0_stored", ra_data, 32'h0);

        // 10 instructions, 3 bubbles, then halt with write to r7
        for (int i = 0; i < 10; i++) begin
            instruction_mem_wb = 32'h20000001 + i;
            tick();
        end
        instruction_mem_wb = 32'h0;
        repeat (3) tick();
        chk("count_10", {28'h0, retired_count}, 32'd10);
        instruction_mem_wb = 32'h0000000C;
        halt_mem_wb = 1'b1;
        write_rd(5'd7, 32'h00000055);
        #1;
        chk("halt_we", {31'h0, wb_we}, 32'h1);
        tick();
        idle();
        ra_addr = 5'd7;
        #1;
        chk("halted", {31'h0, halted}, 32'h1);
        chk("count_11", {28'h0, retired_count}, 32'd11);
        chk("halt_r7", ra_data, 32'h00000055);

        // writes and counting suppressed while halted
        instruction_mem_wb = 32'h00000123;
        write_rd(5'd8, 32'h000000AA);
        ra_addr = 5'd8;
        #1;
        chk("halted_no_we", {31'h0, wb_we}, 32'h0);
        tick();
        idle();
        #1;
        chk("halted_r8", ra_data, 32'h0);
        chk("halted_count", {28'h0, retired_count}, 32'd11);

        // asynchronous reset between edges
        ra_addr = 5'd7;
        rb_addr = 5'd31;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_r7", ra_data, 32'h0);
        chk("arst_r31", rb_data, 32'h0);
        chk("arst_halted", {31'h0, halted}, 32'h0);
        chk("arst_count", {28'h0, retired_count}, 32'h0);

        // write pending on the edge while reset is high is lost
        write_rd(5'd3, 32'h33333333);
        tick();
        rst = 1'b0;
        idle();
        ra_addr = 5'd3;
        #1;
        chk("rst_dominates", ra_data, 32'h0);

        // first edge after reset operates normally
        write_rd(5'd4, 32'h00000044);
        instruction_mem_wb = 32'h00000001;
        tick();
        idle();
        ra_addr = 5'd4;
        #1;
        chk("post_rst_write", ra_data, 32'h00000044);
        chk("post_rst_count", {28'h0, retired_count}, 32'd1);

        // counter wrap: reach all-ones then retire one more
        instruction_mem_wb = 32'h00000002;
        repeat (14) tick();
        chk("count_ones", {28'h0, retired_count}, 32'd15);
        tick();
        instruction_mem_wb = 32'h0;
        #1;
        chk("count_wrap", {28'h0, retired_count}, 32'd0);
        chk("wrap_not_halted", {31'h0, halted}, 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter RETIRE_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 pc_mem_wb  input  32  PC of the instruction now in WB.
REQ-005 instruction_mem_wb  input  32  instruction word in WB; 32'h0 denotes a bubble.
REQ-006 MemtoReg_mem_wb  input  1  1 = write-back data from RAM, 0 = from ALU.
REQ-007 Jump_mem_wb  input  2  jump class: 00 none, 01 j, 10 jal, 11 jr.
REQ-008 rt_mem_wb, rd_mem_wb  input  5 each  candidate destination registers.
REQ-009 alu_out_mem_wb, ram_read_data_mem_wb  input  32 each  write-back data sources.
REQ-010 RegDst_mem_wb  input  1  1 = destination rd, 0 = destination rt.
REQ-011 RegWrite_mem_wb  input  1  register write request.
REQ-012 halt_mem_wb  input  1  halt instruction in WB.
REQ-013 ra_addr, rb_addr  input  5 each  decode-stage read addresses.
REQ-014 ra_data, rb_data  output  32 each  read data, combinational.
REQ-015 wb_we, wb_addr[5], wb_data[32]  output  effective write this cycle, for the forwarding unit.
REQ-016 halted  output  1  sticky halt status.
REQ-017 retired_count  output  RETIRE_W  retired-instruction count.

Function
REQ-018 Destination SHALL be 31 when Jump_mem_wb=10 (jal), else rd_mem_wb if RegDst_mem_wb=1, else rt_mem_wb.
REQ-019 Write data SHALL be pc_mem_wb+4 for jal, else ram_read_data_mem_wb if MemtoReg_mem_wb=1, else alu_out_mem_wb; addition modulo 2^32.
REQ-020 wb_we SHALL be (RegWrite_mem_wb or jal) and halted=0 and destination!=0, combinationally.
REQ-021 When wb_we=1, the register file entry wb_addr SHALL take wb_data at the next rising clk edge; no other entry changes.
REQ-022 Register 0 SHALL always read 0; writes to it are discarded.
REQ-023 ra_data/rb_data SHALL return wb_data when wb_we=1 and the address equals wb_addr (write-through bypass), else the stored value.
REQ-024 Both read ports addressing the same register SHALL return identical data.
REQ-025 State machine RUN/HALTED: RUN -> HALTED on a rising edge with halt_mem_wb=1; HALTED exits only by reset; halted=1 in HALTED.
REQ-026 In HALTED, register writes and counting SHALL be suppressed; reads remain functional.
REQ-027 In RUN, retired_count SHALL increment by 1 per edge with instruction_mem_wb!=0, including the halt instruction itself.
REQ-028 retired_count SHALL wrap from all-ones to 0 without flagging.
REQ-029 halt_mem_wb with RegWrite_mem_wb in the same cycle: the write SHALL occur (halted still 0 that cycle), then HALTED.

Reset
REQ-030 rst=1 SHALL immediately clear all 32 registers to 0, halted to 0, retired_count to 0, and state to RUN, independent of clk.
REQ-031 A write pending at the edge coincident with rst SHALL be lost; reset dominates.
REQ-032 After rst deasserts, the first rising edge SHALL operate normally.

Structure
REQ-033 Jump encodings (JUMP_NONE/J/JAL/JR), REG_RA=31, and the RUN/HALTED enum SHALL live in the shared package mips_pkg.
REQ-034 Storage SHALL be a sub-module regfile_2r1w (32x32, two combinational read ports, one synchronous write, async reset, r0 hardwired).
REQ-035 Destination/data muxing, bypass, halt FSM and counter SHALL reside in wb_regfile.

Verification
REQ-036 RegWrite=1, RegDst=1, rd=5, MemtoReg=0, alu_out=0xDEADBEEF; next cycle ra_addr=5 -> ra_data=0xDEADBEEF; same cycle as write -> bypassed 0xDEADBEEF.
REQ-037 Jump=10, pc=0x00400010, RegWrite=0 -> r31=0x00400014, wb_addr=31.
REQ-038 Write to r0 with data 0x12345678 -> wb_we=0, ra_addr=0 reads 0.
REQ-039 10 nonzero instructions, 3 bubbles, then halt with RegWrite to r7=0x55 -> retired_count=11, r7=0x55, halted=1; later writes ignored, count frozen.
REQ-040 Preload counter path to all-ones, retire 1 -> retired_count=0.
REQ-041 Assert rst mid-stream between edges -> all registers, halted, retired_count read 0 before the next clk edge.
